// File: rtl/sp_ram_pkg.sv
// Shared constants and sequencer state type for the single-port scratch RAM.
package sp_ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  // IDLE is the all-zero encoding so an un-reset register comes up idle.
  typedef enum logic {
    CLEAR = 1'b1,
    IDLE  = 1'b0
  } seq_state_t;

endpackage

// File: rtl/sp_ram_clear_seq.sv
// Post-reset clear sweep: walks every address once, then hands the write port
// back to the user.
module sp_ram_clear_seq
  import sp_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic              clr_sel,
  output logic [ADDR_W-1:0] ptr
);

  seq_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      ptr       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == {ADDR_W{1'b1}}) begin
            state     <= IDLE;
            init_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clr_sel = (state == CLEAR);

endmodule

// File: rtl/sp_ram.sv
// 2**ADDR_W x DATA_W single-port RAM, write-first registered read, zeroed by
// an internal sweep after every reset.
module sp_ram
  import sp_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic [DATA_W-1:0] Q,
  output logic              init_busy
);

  localparam int NWORDS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NWORDS];
  logic              clr_sel;
  logic [ADDR_W-1:0] clr_ptr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  sp_ram_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_sel   (clr_sel),
    .ptr       (clr_ptr)
  );

  // One muxed write port keeps the array inferable as block RAM.
  assign wr_en   = !rst && (clr_sel || we);
  assign wr_addr = clr_sel ? clr_ptr : addr;
  assign wr_data = clr_sel ? '0 : data;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_sel) Q <= '0;
    else if (we)        Q <= data;
    else                Q <= mem[addr];
  end

endmodule

// File: tb/tb_sp_ram.sv
// Directed self-checking bench for sp_ram: clear sweep, readback, write-first,
// busy lockout, mid-operation reset and address extremes.
module tb_sp_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic [5:0] addr;
  logic       we;
  logic [7:0] Q;
  logic       init_busy;

  int n_tests = 0;
  int n_fail  = 0;

  sp_ram dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .addr      (addr),
    .we        (we),
    .Q         (Q),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic cyc(input logic w, input logic [5:0] a, input logic [7:0] d);
    we = w; addr = a; data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input string tag, input logic [5:0] a, input logic [7:0] d);
    cyc(1'b1, a, d);
    chk(tag, {24'b0, Q}, {24'b0, d});
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
    cyc(1'b0, a, 8'h00);
    chk(tag, {24'b0, Q}, {24'b0, exp});
  endtask

  // Two reset cycles, then count busy cycles while hammering a write at 5.
  task automatic reset_and_sweep(input string tag);
    int  cnt;
    bit  q_bad;
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk({tag, "_rst_q"}, {24'b0, Q}, 32'h0);
    chk({tag, "_rst_busy"}, {31'b0, init_busy}, 32'h1);
    rst = 1'b0;
    we = 1'b1; addr = 6'd5; data = 8'h5A;
    cnt = 0; q_bad = 1'b0;
    while (init_busy && cnt < 200) begin
      if (Q !== 8'h00) q_bad = 1'b1;
      cnt++;
      @(negedge clk);
    end
    we = 1'b0;
    chk({tag, "_busy_cycles"}, cnt, 32'd64);
    chk({tag, "_q_zero_sweep"}, {31'b0, q_bad}, 32'h0);
    chk({tag, "_busy_low"}, {31'b0, init_busy}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; data = '0;
    @(negedge clk);

    reset_and_sweep("init");
    rd("rd0_clear",  6'd0,  8'h00);
    rd("rd3_clear",  6'd3,  8'h00);
    rd("rd63_clear", 6'd63, 8'h00);
    rd("rd5_busy_wr_ignored", 6'd5, 8'h00);

    wr("wr_aa0", 6'd0, 8'hAA);
    wr("wr_bb1", 6'd1, 8'hBB);
    wr("wr_cc2", 6'd2, 8'hCC);
    rd("rd_aa0", 6'd0, 8'hAA);
    rd("rd_bb1", 6'd1, 8'hBB);
    rd("rd_cc2", 6'd2, 8'hCC);

    wr("wr_dd1", 6'd1, 8'hDD);
    rd("rd_dd1", 6'd1, 8'hDD);
    rd("rd3_unwritten", 6'd3, 8'h00);

    wr("wr_3c63", 6'd63, 8'h3C);
    wr("wr_c30",  6'd0,  8'hC3);
    rd("rd_3c63", 6'd63, 8'h3C);
    rd("rd_c30",  6'd0,  8'hC3);

    // Write 77@10, then reset on the same edge as a write of 99@10.
    wr("wr_77_10", 6'd10, 8'h77);
    rd("rd_77_10", 6'd10, 8'h77);
    we = 1'b1; addr = 6'd10; data = 8'h99;
    reset_and_sweep("midop");
    rd("rd10_after_rst", 6'd10, 8'h00);
    rd("rd0_after_rst",  6'd0,  8'h00);
    rd("rd63_after_rst", 6'd63, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
